// File: rtl/soc_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_onchip_mem_arbiter
// Purpose  : Two-master round-robin arbiter in front of a single-port on-chip
//            memory. It issues at most one memory access per cycle, stalls the
//            losing master with waitrequest, and returns the one-cycle read
//            response to the master that issued the read.
// Ports    : clk, reset_n (async, active-low)
//            m0_* / m1_*  Avalon-MM slave side (address, byteenable, read,
//                         write, writedata, waitrequest, readdata,
//                         readdatavalid)
//            mem_*        memory s1 side (address, byteenable, writedata,
//                         chipselect, write, clken, readdata)
// Options  : SOC_MEM_ARB_LOCK_EN adds m0_lock / m1_lock. A master that won the
//            last grant and holds lock keeps winning ties while it requests.
// Revision : 1.0 - initial release
// ============================================================================
module soc_onchip_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef SOC_MEM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  // master 0
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // memory
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic w_req0;
  logic w_req1;
  logic w_tie_pick1;
  logic w_grant0;
  logic w_grant1;
  logic w_any_grant;
  logic w_sel_write;
  logic w_rd_accept;

  // last_grant resets to 1 so that master 0 wins the first tie
  logic r_last_grant;
  logic r_rd_pend;
  logic r_rd_owner;

  // A write strobe dominates: read+write together is a write
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Tie resolution: normally the master that did not win last time
  always_comb begin
    w_tie_pick1 = ~r_last_grant;
`ifdef SOC_MEM_ARB_LOCK_EN
    // Lock lets the previous winner keep the memory on ties
    if (!r_last_grant && m0_lock) begin
      w_tie_pick1 = 1'b0;
    end
    if (r_last_grant && m1_lock) begin
      w_tie_pick1 = 1'b1;
    end
`endif
  end

  // Grants are masked by reset so nothing reaches the memory while in reset
  assign w_grant0    = reset_n & w_req0 & (~w_req1 | ~w_tie_pick1);
  assign w_grant1    = reset_n & w_req1 & (~w_req0 |  w_tie_pick1);
  assign w_any_grant = w_grant0 | w_grant1;

  assign m0_waitrequest = w_req0 & ~w_grant0;
  assign m1_waitrequest = w_req1 & ~w_grant1;

  // Master 0 is the default mux leg, so idle cycles show its values
  assign mem_address    = w_grant1 ? m1_address    : m0_address;
  assign mem_byteenable = w_grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_grant1 ? m1_writedata  : m0_writedata;

  assign w_sel_write    = w_grant1 ? m1_write : (w_grant0 & m0_write);
  assign w_rd_accept    = w_any_grant & ~w_sel_write;

  assign mem_chipselect = w_any_grant;
  assign mem_write      = w_sel_write;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      if (w_any_grant) begin
        r_last_grant <= w_grant1;
      end
      // Memory returns data one cycle after the address edge, so a single
      // pending slot is enough to keep back-to-back reads in order
      r_rd_pend  <= w_rd_accept;
      r_rd_owner <= w_rd_accept & w_grant1;
    end
  end

  assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = r_rd_pend &  r_rd_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
`default_nettype wire
